// File: rtl/video_frame_buffer_if.sv
// rtl/video_frame_buffer_if.sv - command handshake bundle between CPU draw issuer and frame buffer
interface video_frame_buffer_if #(
  parameter int BUF_WIDTH  = 128,
  parameter int BUF_HEIGHT = 64
);
  localparam int XW = $clog2(BUF_WIDTH);
  localparam int YW = $clog2(BUF_HEIGHT);

  logic          hires;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [7:0]    cmd_data;
  logic          done;
  logic          collision;
  logic          busy;

  modport master (
    output hires, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready, done, collision, busy
  );

  modport slave (
    input  hires, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready, done, collision, busy
  );
endinterface

// File: rtl/video_frame_buffer.sv
// rtl/video_frame_buffer.sv - monochrome CHIP-8/SCHIP frame buffer with draw commands and RGB scan-out
module video_frame_buffer #(
  parameter int         BUF_WIDTH  = 128,
  parameter int         BUF_HEIGHT = 64,
  parameter int         PIXEL_SIZE = 5,
  parameter int         X_OFFSET   = 0,
  parameter int         Y_OFFSET   = 80,
  parameter logic [11:0] FG_RGB    = 12'h0F0,
  parameter logic [11:0] BG_RGB    = 12'h000
) (
  input  logic                clock,
  input  logic                reset,
  video_frame_buffer_if.slave cmd,
  input  logic [31:0]         pxl_x,
  input  logic [31:0]         pxl_y,
  output logic [3:0]          Red_level,
  output logic [3:0]          Green_level,
  output logic [3:0]          Blue_level
);
  localparam int XW = $clog2(BUF_WIDTH);
  localparam int YW = $clog2(BUF_HEIGHT);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_DRAW = 2'd2;
  localparam logic [1:0] OP_SET  = 2'd3;

  typedef enum logic [1:0] {S_INIT_CLR, S_IDLE, S_CLR, S_DRAW} state_t;

  state_t         r_state;
  logic [YW-1:0]  r_row;
  logic           r_ready;
  logic           r_done;
  logic           r_coll;
  logic [1:0]     r_op;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [7:0]     r_data;
  logic           r_lores;
  logic           r_sub;
  logic [11:0]    r_rgb;

  logic [BUF_WIDTH-1:0] r_mem [BUF_HEIGHT];

  logic [7:0]           w_rev;
  logic [15:0]          w_pair;
  logic [XW-1:0]        w_lx2;
  logic [BUF_WIDTH-1:0] w_sprite;
  logic [BUF_WIDTH-1:0] w_dot;
  logic [BUF_WIDTH-1:0] w_old;
  logic [BUF_WIDTH-1:0] w_wdata;
  logic [YW-1:0]        w_drow;
  logic [YW-1:0]        w_waddr;
  logic                 w_we;
  logic                 w_hit;

  // Sprite row reversed so bit i is logical column x+i; lores doubles each bit horizontally
  always_comb begin
    w_rev  = '0;
    w_pair = '0;
    for (int i = 0; i < 8; i++) begin
      w_rev[i]      = r_data[7-i];
      w_pair[2*i]   = r_data[7-i];
      w_pair[2*i+1] = r_data[7-i];
    end
  end

  // Left shift drops bits past the right edge, which gives clipping instead of wrap
  assign w_lx2    = {r_x[XW-2:0], 1'b0};
  assign w_sprite = r_lores ? (BUF_WIDTH'(w_pair) << w_lx2) : (BUF_WIDTH'(w_rev) << r_x);
  assign w_dot    = r_lores ? (BUF_WIDTH'(2'b11) << w_lx2) : (BUF_WIDTH'(1'b1) << r_x);
  assign w_drow   = r_lores ? {r_y[YW-2:0], r_sub} : r_y;
  assign w_old    = r_mem[w_drow];
  assign w_hit    = |(w_old & w_sprite);

  // Row write port: clear sweeps write zeros, draw does a whole-row read-modify-write
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_row;
    w_wdata = '0;
    case (r_state)
      S_INIT_CLR, S_CLR: w_we = 1'b1;
      S_DRAW: begin
        w_we    = 1'b1;
        w_waddr = w_drow;
        if (r_op == OP_SET)
          w_wdata = r_data[0] ? (w_old | w_dot) : (w_old & ~w_dot);
        else
          w_wdata = w_old ^ w_sprite;
      end
      default: ;
    endcase
  end

  // Storage has no reset; the INIT_CLR sweep zeroes it after reset
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Command FSM: clear sweeps, draw rows, done/collision/ready registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT_CLR;
      r_row   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_coll  <= 1'b0;
      r_op    <= OP_NOP;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
      r_lores <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_INIT_CLR, S_CLR: begin
          r_row <= r_row + YW'(1);
          if (r_row == YW'(BUF_HEIGHT - 1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= (r_state == S_CLR);
          end
        end
        S_IDLE: begin
          if (cmd.cmd_valid && r_ready) begin
            r_op    <= cmd.cmd_op;
            r_x     <= cmd.cmd_x;
            r_y     <= cmd.cmd_y;
            r_data  <= cmd.cmd_data;
            r_lores <= ~cmd.hires;
            r_coll  <= 1'b0;
            r_sub   <= 1'b0;
            case (cmd.cmd_op)
              OP_NOP: r_done <= 1'b1;
              OP_CLR: begin
                r_state <= S_CLR;
                r_row   <= '0;
                r_ready <= 1'b0;
              end
              default: begin
                r_state <= S_DRAW;
                r_ready <= 1'b0;
              end
            endcase
          end
        end
        S_DRAW: begin
          if (r_op == OP_DRAW) r_coll <= r_coll | w_hit;
          if (r_lores && !r_sub) begin
            r_sub <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_INIT_CLR;
      endcase
    end
  end

  // Scan-out window: a 33-bit subtract exposes "left of/above window" in the top bit
  logic [32:0] w_dx;
  logic [32:0] w_dy;
  logic [31:0] w_colq;
  logic [31:0] w_rowq;
  logic        w_in;
  logic        w_bit;

  assign w_dx   = {1'b0, pxl_x} - 33'(X_OFFSET);
  assign w_dy   = {1'b0, pxl_y} - 33'(Y_OFFSET);
  assign w_colq = w_dx[31:0] / 32'(PIXEL_SIZE);
  assign w_rowq = w_dy[31:0] / 32'(PIXEL_SIZE);
  assign w_in   = !w_dx[32] && !w_dy[32] &&
                  (w_colq < 32'(BUF_WIDTH)) && (w_rowq < 32'(BUF_HEIGHT));
  assign w_bit  = r_mem[w_rowq[YW-1:0]][w_colq[XW-1:0]];

  // Registered colour; reads the pre-write value when a write hits the same bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rgb <= BG_RGB;
    else       r_rgb <= (w_in && w_bit) ? FG_RGB : BG_RGB;
  end

  assign Red_level     = r_rgb[11:8];
  assign Green_level   = r_rgb[7:4];
  assign Blue_level    = r_rgb[3:0];
  assign cmd.cmd_ready = r_ready;
  assign cmd.busy      = ~r_ready;
  assign cmd.done      = r_done;
  assign cmd.collision = r_coll;
endmodule

// File: tb/tb_video_frame_buffer.sv
// tb/tb_video_frame_buffer.sv - scoreboard bench for video_frame_buffer with randomized draw commands
module tb_video_frame_buffer;
  localparam int W  = 128;
  localparam int H  = 64;
  localparam int PS = 5;
  localparam int XO = 0;
  localparam int YO = 80;
  localparam logic [11:0] FG = 12'h0F0;
  localparam logic [11:0] BG = 12'h000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pxl_x = 32'd0;
  logic [31:0] pxl_y = 32'd0;
  logic [3:0]  red, green, blue;

  video_frame_buffer_if #(.BUF_WIDTH(W), .BUF_HEIGHT(H)) vif ();

  video_frame_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (vif),
    .pxl_x       (pxl_x),
    .pxl_y       (pxl_y),
    .Red_level   (red),
    .Green_level (green),
    .Blue_level  (blue)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference picture of the physical buffer
  bit mdl [H][W];

  typedef struct {
    int acc;
    int lat;
    bit coll;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [11:0] exp_rgb(input int px, input int py);
    if (px >= XO && px < XO + W * PS && py >= YO && py < YO + H * PS)
      return mdl[(py - YO) / PS][(px - XO) / PS] ? FG : BG;
    return BG;
  endfunction

  // Applies one command to the picture from the logical-pixel rules
  task automatic model_apply(input int op, input int x, input int y, input logic [7:0] d,
                             input bit h, output int lat, output bit coll);
    int lw, lh, s, lx, ly;
    lw = h ? W : W / 2;
    lh = h ? H : H / 2;
    s  = h ? 1 : 2;
    lx = x % lw;
    ly = y % lh;
    coll = 1'b0;
    lat  = 0;
    case (op)
      0: lat = 0;
      1: begin
        foreach (mdl[r, c]) mdl[r][c] = 1'b0;
        lat = H;
      end
      2: begin
        for (int i = 0; i < 8; i++)
          if (lx + i < lw && d[7-i])
            for (int dy = 0; dy < s; dy++)
              for (int dx = 0; dx < s; dx++) begin
                if (mdl[ly*s+dy][(lx+i)*s+dx]) coll = 1'b1;
                mdl[ly*s+dy][(lx+i)*s+dx] = !mdl[ly*s+dy][(lx+i)*s+dx];
              end
        lat = s;
      end
      default: begin
        for (int dy = 0; dy < s; dy++)
          for (int dx = 0; dx < s; dx++)
            mdl[ly*s+dy][lx*s+dx] = d[0];
        lat = s;
      end
    endcase
  endtask

  task automatic issue(input int op, input int x, input int y, input logic [7:0] d,
                       input bit h, output int acc);
    int   n;
    exp_t e;
    @(negedge clock);
    vif.cmd_valid = 1'b1;
    vif.cmd_op    = 2'(op);
    vif.cmd_x     = 7'(x);
    vif.cmd_y     = 6'(y);
    vif.cmd_data  = d;
    vif.hires     = h;
    n = 0;
    while (!vif.cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    acc = cyc + 1;
    if (!vif.cmd_ready) begin
      fail_bound("accept");
      vif.cmd_valid = 1'b0;
      return;
    end
    model_apply(op, x, y, d, h, e.lat, e.coll);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    vif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !vif.cmd_ready) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) fail_bound("idle");
  endtask

  task automatic scan(input int px, input int py, output logic [11:0] v);
    @(negedge clock);
    pxl_x = 32'(px);
    pxl_y = 32'(py);
    @(negedge clock);
    v = {red, green, blue};
  endtask

  task automatic scan_const(input string nm, input int px, input int py, input logic [11:0] req);
    logic [11:0] v;
    scan(px, py, v);
    chk(nm, 32'(v), 32'(req));
  endtask

  task automatic scan_model(input string nm, input int px, input int py);
    logic [11:0] v;
    scan(px, py, v);
    chk(nm, 32'(v), 32'(exp_rgb(px, py)));
  endtask

  // Pipelined sweep over every pixel centre; one comparison reports the number of wrong pixels
  task automatic sweep(input string nm);
    int          bad;
    logic [11:0] prev;
    bad  = 0;
    prev = BG;
    for (int i = 0; i <= W * H; i++) begin
      @(negedge clock);
      if (i > 0 && {red, green, blue} !== prev) bad++;
      if (i < W * H) begin
        pxl_x = 32'(XO + (i % W) * PS + 2);
        pxl_y = 32'(YO + (i / W) * PS + 2);
        prev  = exp_rgb(XO + (i % W) * PS + 2, YO + (i / W) * PS + 2);
      end
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  task automatic do_release(input string nm);
    int r, n;
    @(negedge clock);
    reset = 1'b0;
    r = cyc;
    n = 0;
    while (!vif.cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(cyc - r), 32'd64);
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clock) begin
    if (!reset) begin
      chk("busy_vs_ready", 32'(vif.busy), 32'(!vif.cmd_ready));
      if (vif.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("collision", 32'(vif.collision), 32'(mon_e.coll));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, n, op, x, y;
    logic [7:0]  d;
    bit          h;
    logic [11:0] v;

    vif.cmd_valid = 1'b0;
    vif.cmd_op    = 2'd0;
    vif.cmd_x     = '0;
    vif.cmd_y     = '0;
    vif.cmd_data  = '0;
    vif.hires     = 1'b1;
    foreach (mdl[r, c]) mdl[r][c] = 1'b0;

    // Reset state and init sweep
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(vif.cmd_ready), 32'd0);
    chk("rst_done", 32'(vif.done), 32'd0);
    chk("rst_collision", 32'(vif.collision), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'(BG));
    do_release("init_ready_latency");
    sweep("init_all_zero");

    // Hires draw, then the same draw again erases with collision
    issue(2, 10, 5, 8'hF0, 1'b1, acc);
    wait_idle();
    scan_const("t2_scan_set", 50, 105, 12'h0F0);
    scan_model("t2_scan_col13", 13 * PS + 1, YO + 5 * PS);
    scan_const("t2_scan_col14", 14 * PS, YO + 5 * PS, BG);
    issue(2, 10, 5, 8'hF0, 1'b1, acc);
    wait_idle();
    chk("t2_coll_held", 32'(vif.collision), 32'd1);
    scan_const("t2_scan_cleared", 50, 105, BG);

    // Lores clipping at the right edge and start wrap
    issue(2, 62, 31, 8'hFF, 1'b0, acc);
    wait_idle();
    chk("t3_coll", 32'(vif.collision), 32'd0);
    scan_const("t3_col124_row62", 124 * PS, YO + 62 * PS, FG);
    scan_const("t3_col127_row63", 127 * PS + 4, YO + 63 * PS + 4, FG);
    scan_const("t3_col123_row62", 123 * PS, YO + 62 * PS, BG);
    scan_const("t3_col124_row61", 124 * PS, YO + 61 * PS, BG);
    issue(2, 66, 0, 8'h80, 1'b0, acc);
    wait_idle();
    scan_const("t3_wrap_col4", 4 * PS, YO, FG);
    scan_const("t3_wrap_col5_row1", 5 * PS, YO + PS, FG);
    scan_const("t3_wrap_col6", 6 * PS, YO, BG);

    // Window border
    issue(3, 0, 0, 8'h01, 1'b1, acc);
    wait_idle();
    scan_const("t4_y80", 0, 80, FG);
    scan_const("t4_y79", 0, 79, BG);
    scan_const("t4_y400", 0, 400, BG);
    scan_const("t4_x640", 640, 80, BG);

    // CLEAR with commands presented while busy
    issue(1, 0, 0, 8'h00, 1'b1, acc);
    vif.cmd_op   = 2'd2;
    vif.cmd_data = 8'hFF;
    vif.cmd_x    = 7'd20;
    vif.cmd_y    = 6'd20;
    vif.hires    = 1'b1;
    n = 0;
    while (!vif.cmd_ready && n < 200) begin
      vif.cmd_valid = (cyc - acc < 40);
      @(negedge clock);
      n++;
    end
    vif.cmd_valid = 1'b0;
    chk("t5_busy_cycles", 32'(cyc - acc), 32'd64);
    wait_idle();
    sweep("t5_all_zero");

    // Reset during CLR row 20
    issue(3, 3, 40, 8'h01, 1'b1, acc);
    wait_idle();
    @(negedge clock);
    pxl_x = 32'(3 * PS + 2);
    pxl_y = 32'(YO + 40 * PS + 2);
    issue(1, 0, 0, 8'h00, 1'b1, acc);
    n = 0;
    while (cyc - acc < 20 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("t6_pre_rgb", 32'({red, green, blue}), 32'(FG));
    reset = 1'b1;
    sb.delete();
    foreach (mdl[r, c]) mdl[r][c] = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(vif.cmd_ready), 32'd0);
    chk("t6_rst_done", 32'(vif.done), 32'd0);
    chk("t6_rst_collision", 32'(vif.collision), 32'd0);
    chk("t6_rst_rgb", 32'({red, green, blue}), 32'(BG));
    repeat (2) @(negedge clock);
    do_release("t6_init_ready_latency");
    sweep("t6_all_zero");

    // Randomized commands against the reference picture
    for (int k = 0; k < 60; k++) begin
      n  = int'($urandom_range(0, 15));
      op = (n == 0) ? 1 : (n < 3) ? 0 : (n < 10) ? 2 : 3;
      x  = int'($urandom_range(0, W - 1));
      y  = int'($urandom_range(0, H - 1));
      d  = 8'($urandom);
      h  = 1'($urandom);
      issue(op, x, y, d, h, acc);
      wait_idle();
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) == 0)
          scan_model("rand_scan", int'($urandom_range(0, 700)), int'($urandom_range(0, 479)));
        else
          scan_model("rand_scan_win", int'($urandom_range(0, W * PS - 1)),
                     YO + int'($urandom_range(0, H * PS - 1)));
      end
    end
    sweep("final_picture");
    scan(0, 0, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
